gs_bfu_inv: RTL and testbench
=============================

Name: gs_bfu_inv

Overview:
Pipelined Gentleman-Sande (inverse-NTT) butterfly for the Ncc-Sign polynomial engine. It is the inverse-direction counterpart to the forward Cooley-Tukey butterfly (`compact_BFU_no`): for each accepted pair it computes a1 = (a+b) mod Q and b1 = ((a-b) mod Q)·omega mod Q. Both results can optionally be scaled by 2^-1 mod Q, so that the INTT's final n^-1 factor is applied stage by stage. It sits in the INTT datapath between the coefficient-RAM read port and the write-back port, accepting one butterfly per cycle.

Parameters:
- PARAM_Q, 134250497: modulus; odd; must satisfy 2^(D-1) < PARAM_Q < 2^D.
- D, 28: coefficient width in bits.
- MU, floor(2^(2D)/PARAM_Q): Barrett constant; D+1 bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a/b/omega/half_en are valid this cycle.
- half_en  in  1  1: multiply both outputs by 2^-1 mod Q.
- a  in  D  upper coefficient, range [0, Q-1].
- b  in  D  lower coefficient, range [0, Q-1].
- omega  in  D  inverse twiddle, range [0, Q-1].
- out_valid  out  1  a1/b1 are valid this cycle.
- a1  out  D  (a+b)·s mod Q, where s = 2^-1 if half_en else 1.
- b1  out  D  (a-b)·omega·s mod Q.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset:
  - On any rising edge with rst=1, every valid bit in the pipeline clears.
  - out_valid, a1 and b1 are 0 in the cycle after that edge.
  - Data registers may hold stale values internally, but a1/b1 are forced to 0 whenever out_valid=0.
- Throughput: one butterfly per cycle, no stall and no backpressure. in_valid may be high continuously.
- Latency: fixed 5 cycles. A pair sampled at edge k produces out_valid=1 with its results after edge k+5. Results leave in input order.
- S1 (add/sub):
  - sum = a+b; if sum ≥ Q then sum −= Q.
  - diff = a−b; if negative then diff += Q.
  - Register sum, diff, omega, half_en and valid.
- S2 (multiply): P = diff·omega, 2D bits, registered. sum is delayed alongside.
- S3 (Barrett estimate): t = ((P >> (D−1))·MU) >> (D+1); r = P − t·Q, computed on D+2 bits. Registered.
- S4 (correction): at most two conditional subtractions of Q, giving r in [0, Q−1]. Registered.
- S5 (halve, both paths): if half_en=0, output x unchanged. If x is even, output x>>1. If x is odd, output (x+Q)>>1, computed on D+1 bits. Registered into a1/b1.
- half_en travels with its data, so switching it per cycle is legal.
- Boundaries:
  - Inputs ≥ Q give undefined outputs; the bench must not drive them.
  - a=b gives b1=0.
  - omega=0 gives b1=0.
  - A sum of exactly Q reduces to 0.
- Reset mid-stream: any in-flight butterfly is discarded and no out_valid pulse emerges for it. An in_valid asserted in the same cycle as rst is ignored.
- No combinational path from any input to any output.

Decomposition:
- Shared package ntt_pkg holds:
  - PARAM_Q, D, MU and Q_INV2 = (Q+1)/2 (reference value for the bench);
  - the coefficient typedef coeff_t, logic [D-1:0].
- Sub-module mod_mul_barrett (clk, rst, in_valid, x, y, out_valid, r), latency 3, covering S2–S4. It is to be reused later by the forward butterfly and the pointwise multiplier.
- Add/sub (S1) and halving (S5) stay inline.

Test Plan:
- Basic: rst, then a=10, b=4, omega=1, half_en=0 → 5 cycles later out_valid=1, a1=14, b1=6.
- Wrap: a=3, b=5, omega=1, half_en=0 → a1=8, b1=134250495. Then a=q-1, b=q-1, omega=2 → a1=134250495, b1=0.
- Halving: a=3, b=4, omega=1, half_en=1 → a1=67125252 (odd sum), b1=67125248 (even q-1).
- Reduction: a=5, b=2, omega=134250496, half_en=0 → a1=7, b1=134250494. Follow with 1000 random in-range vectors checked against a reference model using a 64-bit % operation.
- Streaming: 16 back-to-back vectors with in_valid held high, half_en toggling each cycle → 16 consecutive out_valid cycles, correct order, no gaps.
- Reset mid-operation: 3 vectors issued, rst pulsed at cycle 2 for one cycle → none of them emerge; out_valid, a1 and b1 stay 0. A vector issued after reset completes normally with 5-cycle latency.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, coefficient type and small arithmetic helpers for the NTT datapath.
package ntt_pkg;

  localparam int D = 28;
  localparam logic [D-1:0] PARAM_Q = 28'd134250497;
  localparam logic [63:0] MU_WIDE = (64'd1 << (2*D)) / {{(64-D){1'b0}}, PARAM_Q};
  localparam logic [D:0] MU = MU_WIDE[D:0];
  localparam logic [D-1:0] Q_INV2 = {1'b0, PARAM_Q[D-1:1]} + {{(D-1){1'b0}}, 1'b1};

  typedef logic [D-1:0] coeff_t;

  // Barrett quotient estimate; undershoots the true quotient by at most 2.
  function automatic logic [D:0] barrett_quot(input logic [2*D-1:0] p);
    logic [2*D+1:0] prod;
    prod = {{(D+1){1'b0}}, p[2*D-1:D-1]} * {{(D+1){1'b0}}, MU};
    return (D+1)'(prod >> (D+1));
  endfunction

  function automatic coeff_t reduce_fix(input logic [D+1:0] x);
    logic [D+1:0] y;
    y = (x >= {2'b00, PARAM_Q}) ? x - {2'b00, PARAM_Q} : x;
    y = (y >= {2'b00, PARAM_Q}) ? y - {2'b00, PARAM_Q} : y;
    return coeff_t'(y);
  endfunction

  // Multiplying by 2^-1 mod Q: an odd value is made even by adding Q before shifting.
  function automatic coeff_t halve(input coeff_t x, input logic en);
    logic [D:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, PARAM_Q} : {(D+1){1'b0}});
    return en ? coeff_t'(s >> 1) : x;
  endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// Three-stage modular multiplier: product, Barrett estimate, final correction.
module mod_mul_barrett
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  output logic         out_valid,
  output logic [D-1:0] r
);

  logic           v2;
  logic           v3;
  logic [2*D-1:0] p;
  logic [D:0]     t;
  logic [D+1:0]   tq;
  logic [D+1:0]   r_est;

  assign t  = barrett_quot(p);
  // Only the low D+2 bits matter since the remainder estimate is below 3Q.
  assign tq = {1'b0, t} * {2'b00, PARAM_Q};

  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v2        <= in_valid;
      v3        <= v2;
      out_valid <= v3;
    end
  end

  always_ff @(posedge clk) begin
    p     <= {{D{1'b0}}, x} * {{D{1'b0}}, y};
    r_est <= (D+2)'(p) - tq;
    r     <= reduce_fix(r_est);
  end

endmodule

// File: rtl/gs_bfu_inv.sv
// Gentleman-Sande inverse butterfly: a1 = (a+b)*s, b1 = (a-b)*omega*s mod Q,
// with s = 2^-1 when half_en is set. Five-stage pipeline, one pair per cycle.
module gs_bfu_inv
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         half_en,
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic [D-1:0] omega,
  output logic         out_valid,
  output logic [D-1:0] a1,
  output logic [D-1:0] b1
);

  logic [D:0] sum_raw;
  logic [D:0] diff_raw;
  coeff_t     sum_c;
  coeff_t     diff_c;

  always_comb begin
    sum_raw  = {1'b0, a} + {1'b0, b};
    diff_raw = {1'b0, a} - {1'b0, b};
    sum_c    = (sum_raw >= {1'b0, PARAM_Q}) ? coeff_t'(sum_raw - {1'b0, PARAM_Q})
                                            : coeff_t'(sum_raw);
    diff_c   = diff_raw[D] ? coeff_t'(diff_raw + {1'b0, PARAM_Q}) : coeff_t'(diff_raw);
  end

  logic   v1;
  logic   half1;
  coeff_t sum1;
  coeff_t diff1;
  coeff_t omega1;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    sum1   <= sum_c;
    diff1  <= diff_c;
    omega1 <= omega;
    half1  <= half_en;
  end

  logic   mul_valid;
  coeff_t mul_r;

  mod_mul_barrett u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .x         (diff1),
    .y         (omega1),
    .out_valid (mul_valid),
    .r         (mul_r)
  );

  // The sum path and the halving flag ride alongside the multiplier's three stages.
  coeff_t sum_d  [3];
  logic   half_d [3];

  always_ff @(posedge clk) begin
    sum_d[0]  <= sum1;
    sum_d[1]  <= sum_d[0];
    sum_d[2]  <= sum_d[1];
    half_d[0] <= half1;
    half_d[1] <= half_d[0];
    half_d[2] <= half_d[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a1        <= '0;
      b1        <= '0;
    end else begin
      out_valid <= mul_valid;
      a1        <= mul_valid ? halve(sum_d[2], half_d[2]) : '0;
      b1        <= mul_valid ? halve(mul_r, half_d[2]) : '0;
    end
  end

endmodule

// File: tb/tb_gs_bfu_inv.sv
// Self-checking bench for gs_bfu_inv: directed hand-computed vectors, a modular
// reference model for random/streaming traffic, and a mid-stream reset.
module tb_gs_bfu_inv;

  localparam longint unsigned QL  = 64'd134250497;
  localparam longint unsigned QI2 = 64'd67125249;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        half_en;
  logic [27:0] a, b, omega;
  logic        out_valid;
  logic [27:0] a1, b1;

  gs_bfu_inv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .half_en   (half_en),
    .a         (a),
    .b         (b),
    .omega     (omega),
    .out_valid (out_valid),
    .a1        (a1),
    .b1        (b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] ea1;
    logic [27:0] eb1;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void refModel(input logic [27:0] va, vb, vw, input logic vh,
                                   output logic [27:0] ea, eb);
    longint unsigned s, d;
    s = (64'(va) + 64'(vb)) % QL;
    d = (((64'(va) + QL - 64'(vb)) % QL) * 64'(vw)) % QL;
    if (vh) begin
      s = (s * QI2) % QL;
      d = (d * QI2) % QL;
    end
    ea = 28'(s);
    eb = 28'(d);
  endfunction

  task automatic applyStimulus(input logic [27:0] va, vb, vw, input logic vh,
                               input logic [27:0] ea, eb, input bit track);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    omega    = vw;
    half_en  = vh;
    if (track) begin
      e.ea1   = ea;
      e.eb1   = eb;
      e.issue = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic goIdle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every valid output must match the oldest expectation with
  // exactly five cycles of latency; idle outputs must read as zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("a1", 64'(a1), 64'(e.ea1));
          checkOutput("b1", 64'(b1), 64'(e.eb1));
          checkOutput("latency", 64'(cyc - e.issue), 64'd5);
        end
      end else begin
        checkOutput("a1_idle", 64'(a1), 64'd0);
        checkOutput("b1_idle", 64'(b1), 64'd0);
      end
    end
  end

  initial begin
    logic [27:0] va, vb, vw, ea, eb;
    logic        vh;

    rst = 1'b1; in_valid = 1'b0; half_en = 1'b0;
    a = '0; b = '0; omega = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_a1", 64'(a1), 64'd0);
    checkOutput("rst_b1", 64'(b1), 64'd0);
    mon_en = 1'b1;

    $display("[TB] basic");
    applyStimulus(28'd10, 28'd4, 28'd1, 1'b0, 28'd14, 28'd6, 1'b1);
    goIdle();
    waitDrain();

    $display("[TB] directed boundaries");
    applyStimulus(28'd3, 28'd5, 28'd1, 1'b0, 28'd8, 28'd134250495, 1'b1);
    applyStimulus(28'd134250496, 28'd134250496, 28'd2, 1'b0, 28'd134250495, 28'd0, 1'b1);
    applyStimulus(28'd3, 28'd4, 28'd1, 1'b1, 28'd67125252, 28'd67125248, 1'b1);
    applyStimulus(28'd5, 28'd2, 28'd134250496, 1'b0, 28'd7, 28'd134250494, 1'b1);
    applyStimulus(28'd134250000, 28'd497, 28'd0, 1'b0, 28'd0, 28'd0, 1'b1);
    applyStimulus(28'd7, 28'd2, 28'd0, 1'b1, 28'd67125253, 28'd0, 1'b1);
    applyStimulus(28'd10, 28'd4, 28'd1, 1'b1, 28'd7, 28'd3, 1'b1);
    goIdle();
    waitDrain();

    $display("[TB] random");
    for (int i = 0; i < 1000; i++) begin
      va = 28'($urandom_range(134250496, 0));
      vb = 28'($urandom_range(134250496, 0));
      vw = 28'($urandom_range(134250496, 0));
      vh = 1'($urandom_range(1, 0));
      refModel(va, vb, vw, vh, ea, eb);
      applyStimulus(va, vb, vw, vh, ea, eb, 1'b1);
      if ($urandom_range(7, 0) == 0) goIdle();
    end
    goIdle();
    waitDrain();

    $display("[TB] streaming");
    for (int i = 0; i < 16; i++) begin
      va = 28'($urandom_range(134250496, 0));
      vb = 28'($urandom_range(134250496, 0));
      vw = 28'($urandom_range(134250496, 0));
      vh = 1'(i % 2);
      refModel(va, vb, vw, vh, ea, eb);
      applyStimulus(va, vb, vw, vh, ea, eb, 1'b1);
    end
    goIdle();
    waitDrain();

    $display("[TB] reset mid-stream");
    applyStimulus(28'd11, 28'd22, 28'd33, 1'b0, 28'd0, 28'd0, 1'b0);
    applyStimulus(28'd44, 28'd55, 28'd66, 1'b1, 28'd0, 28'd0, 1'b0);
    applyStimulus(28'd77, 28'd88, 28'd99, 1'b0, 28'd0, 28'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rst_flush_valid", 64'(out_valid), 64'd0);
    end
    applyStimulus(28'd10, 28'd4, 28'd1, 1'b0, 28'd14, 28'd6, 1'b1);
    goIdle();
    waitDrain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
